// File: rtl/mag_pkg.sv
// Shared types and the two's-complement to magnitude helper for mag_rr_scheduler.
package mag_pkg;

  localparam int IN_W  = 17;
  localparam int OUT_W = 16;

  typedef enum logic {IDLE, HOLD} mag_state_t;

  typedef logic [IN_W-1:0]  mag_in_t;
  typedef logic [OUT_W-1:0] mag_out_t;

  // Negation wraps to 16 bits, so -65536 collapses to zero here.
  function automatic mag_out_t mag_abs(input mag_in_t d);
    if (d[IN_W-1])
      return (~d[OUT_W-1:0]) + 16'd1;
    else
      return d[OUT_W-1:0];
  endfunction

  function automatic logic mag_is_ovf(input mag_in_t d);
    return (d == 17'h10000);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from an internal pointer, wrapping at NUM_REQ-1.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0] ptr;
  logic            found;

  // First requester at or after the pointer wins; index computed modulo NUM_REQ.
  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
    if (en && found) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (en && found)
      ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/mag_rr_scheduler.sv
// Round-robin shared magnitude datapath with a registered, ID-tagged result.
// Define MAG_SAT_EN to saturate -65536 to 0xFFFF and flag it on out_ovf.
module mag_rr_scheduler
  import mag_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    out_valid,
  output logic [OUT_W-1:0]        out_data,
  output logic [ID_W-1:0]         out_id,
  input  logic                    out_ready,
  output logic                    out_ovf
);

  mag_state_t        state;
  logic              grant_en;
  logic              fire;
  logic [ID_W-1:0]   grant_idx;
  mag_in_t           sel;

  // A new sample may only enter when the result register is free or draining this cycle.
  assign grant_en = !rst && ((state == IDLE) || out_ready);
  assign fire     = |req_ready;
  assign sel      = req_data[IN_W*int'(grant_idx) +: IN_W];

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .en        (grant_en),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

`ifdef MAG_SAT_EN
  logic ovf_q;
  assign out_ovf = ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
`ifdef MAG_SAT_EN
      ovf_q     <= 1'b0;
`endif
    end else if (fire) begin
      state     <= HOLD;
      out_valid <= 1'b1;
      out_id    <= grant_idx;
`ifdef MAG_SAT_EN
      out_data  <= mag_is_ovf(sel) ? 16'hFFFF : mag_abs(sel);
      ovf_q     <= mag_is_ovf(sel);
`else
      out_data  <= mag_abs(sel);
`endif
    end else if (state == HOLD && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
  end

endmodule
